// File: rtl/fft_out_reorder_pkg.sv
// Shared definitions for the FFT output reorder stage: default frame
// geometry, the per-bank state encoding and the bit-reversal helper.
package fft_pkg;

    localparam int N_POINTS_DEF = 32;
    localparam int LOG2N_DEF    = $clog2(N_POINTS_DEF);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    // Reverses the low 'width' bits of 'value'; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[width-1-i] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_bank.sv
// One ping-pong bank of the reorder stage: an N_POINTS deep sample store
// with two write ports and two read ports, plus the bank's occupancy FSM.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   EMPTY   | no frame held; the next write beat starts a new frame
//   FILLING | frame partially written, waiting for the final write beat
//   FULL    | complete frame held, waiting for the read side to pick it up
//   READING | frame being streamed out in natural order, two per cycle
module reorder_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = N_POINTS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic                        wr_last,
    input  logic                        abort,
    input  logic [$clog2(N_POINTS)-1:0] wa0,
    input  logic [$clog2(N_POINTS)-1:0] wa1,
    input  logic [DATA_WIDTH-1:0]       wd0,
    input  logic [DATA_WIDTH-1:0]       wd1,
    input  logic                        rd_start,
    input  logic                        rd_end,
    input  logic [$clog2(N_POINTS)-1:0] ra0,
    input  logic [$clog2(N_POINTS)-1:0] ra1,
    output logic [DATA_WIDTH-1:0]       rd0,
    output logic [DATA_WIDTH-1:0]       rd1,
    output logic                        is_full,
    output logic                        is_reading
);

    logic [DATA_WIDTH-1:0] mem [N_POINTS];
    bank_state_t           state_q;
    bank_state_t           state_d;

    // Sample store; the two write addresses of a beat never collide.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa0] <= wd0;
            mem[wa1] <= wd1;
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

    // Bank state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a framing abort throws the partial frame away.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (we) begin
                        state_d = wr_last ? FULL : FILLING;
                    end
                end
                FILLING: begin
                    if (we && wr_last) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (rd_start) begin
                        state_d = READING;
                    end
                end
                READING: begin
                    if (rd_end) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Status flags seen by the read scheduler in the top level.
    always_comb begin
        is_full    = (state_q == FULL);
        is_reading = (state_q == READING);
    end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder stage: takes two-lane samples in bit-reversed order and
// emits them two lanes per cycle in natural order via two ping-pong banks.
// Optional framing check: define FFT_OUT_REORDER_ALIGN_CHECK_EN to add the
// in_last input and the sticky frame_err output.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = N_POINTS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
    input  logic                  in_last,
    output logic                  frame_err,
`endif
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic                  out_valid,
    output logic                  out_last
);

    localparam int LOG2N = $clog2(N_POINTS);
    // Beat counters run over N/2 two-lane beats, so they are one bit narrower.
    localparam int CW    = LOG2N - 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_POINTS / 2 - 1);

    logic             wr_sel;
    logic [CW-1:0]    wr_cnt;
    logic             wr_last;
    logic             abort;
    logic             wr_en;
    logic [LOG2N-1:0] wa0;
    logic [LOG2N-1:0] wa1;

    logic [CW-1:0]    rd_cnt;
    logic             rd_busy;
    logic             rd_end;
    logic [LOG2N-1:0] ra0;
    logic [LOG2N-1:0] ra1;

    logic [1:0]            bank_we;
    logic [1:0]            bank_abort;
    logic [1:0]            bank_full;
    logic [1:0]            bank_reading;
    logic [1:0]            bank_rd_start;
    logic [1:0]            bank_rd_end;
    logic [DATA_WIDTH-1:0] bank_rd0 [2];
    logic [DATA_WIDTH-1:0] bank_rd1 [2];

    // Write-side decode: scatter addresses, framing check and bank enables.
    always_comb begin
        wr_last = (wr_cnt == LAST_BEAT);
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
        abort   = in_valid && (in_last != wr_last);
`else
        abort   = 1'b0;
`endif
        wr_en      = in_valid && !abort;
        wa0        = LOG2N'(bitrev(32'({wr_cnt, 1'b0}), LOG2N));
        wa1        = LOG2N'(bitrev(32'({wr_cnt, 1'b1}), LOG2N));
        bank_we    = {wr_en && wr_sel, wr_en && !wr_sel};
        bank_abort = {abort && wr_sel, abort && !wr_sel};
    end

    // Read scheduling: a FULL bank may start on the same edge the other bank
    // finishes its last beat, which is what keeps frames back to back.
    always_comb begin
        rd_busy       = |bank_reading;
        rd_end        = rd_busy && (rd_cnt == LAST_BEAT);
        bank_rd_start = bank_full & {2{!rd_busy || rd_end}};
        bank_rd_end   = bank_reading & {2{rd_end}};
        ra0           = {rd_cnt, 1'b0};
        ra1           = {rd_cnt, 1'b1};
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .N_POINTS   (N_POINTS)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .we         (bank_we[b]),
            .wr_last    (wr_last),
            .abort      (bank_abort[b]),
            .wa0        (wa0),
            .wa1        (wa1),
            .wd0        (x0),
            .wd1        (x1),
            .rd_start   (bank_rd_start[b]),
            .rd_end     (bank_rd_end[b]),
            .ra0        (ra0),
            .ra1        (ra1),
            .rd0        (bank_rd0[b]),
            .rd1        (bank_rd1[b]),
            .is_full    (bank_full[b]),
            .is_reading (bank_reading[b])
        );
    end

    // Write beat counter; the bank select flips only on a completed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (abort) begin
            wr_cnt <= '0;
        end else if (in_valid) begin
            if (wr_last) begin
                wr_cnt <= '0;
                wr_sel <= !wr_sel;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
    // Sticky framing error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (abort) begin
            frame_err <= 1'b1;
        end
    end
`endif

    // Read beat counter, advancing every cycle a bank is being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
        end else if (rd_busy) begin
            rd_cnt <= rd_end ? '0 : rd_cnt + 1'b1;
        end
    end

    // Output registers; data holds while idle, only the flags drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            y0        <= '0;
            y1        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_busy;
            out_last  <= rd_end;
            if (rd_busy) begin
                y0 <= bank_reading[1] ? bank_rd0[1] : bank_rd0[0];
                y1 <= bank_reading[1] ? bank_rd1[1] : bank_rd1[0];
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: frames are built in natural order,
// scattered onto the lanes in bit-reversed order, and the natural-order
// beats plus the expected first-beat cycle are queued for the monitor.
module tb_fft_out_reorder;

    localparam int DW   = 16;
    localparam int N    = 32;
    localparam int HALF = N / 2;
    localparam int LG   = 5;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] x0       = '0;
    logic [DW-1:0] x1       = '0;
    logic [DW-1:0] y0;
    logic [DW-1:0] y1;
    logic          out_valid;
    logic          out_last;
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
    logic          in_last  = 1'b0;
    logic          frame_err;
`endif

    fft_out_reorder #(
        .DATA_WIDTH (DW),
        .N_POINTS   (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
        .in_last   (in_last),
        .frame_err (frame_err),
`endif
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] y0;
        logic [DW-1:0] y1;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    start_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < LG; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (LG - 1 - i));
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // gap_mode 0: continuous, 1: valid pattern 1,0,0, 2: random gaps.
    // base < 0 gives random samples, otherwise sample i = base + i.
    // Only a complete frame is queued for checking.
    task automatic send_frame(input int gap_mode, input int base, input int nbeats);
        logic [DW-1:0] v [N];
        int last_cyc;
        last_cyc = 0;
        for (int i = 0; i < N; i++) v[i] = (base < 0) ? DW'($urandom) : DW'(base + i);
        for (int c = 0; c < nbeats; c++) begin
            if (c > 0) begin
                if (gap_mode == 1) idle(2);
                else if (gap_mode == 2) idle($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            x0 = v[brev(2 * c)];
            x1 = v[brev(2 * c + 1)];
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
            in_last = (c == HALF - 1);
`endif
            last_cyc = cyc;
        end
        if (nbeats == HALF) begin
            start_q.push_back(last_cyc + 3);
            for (int k = 0; k < HALF; k++) exp_q.push_back('{v[2 * k], v[2 * k + 1], (k == HALF - 1)});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat.
    logic prev_valid = 1'b0;
    logic prev_last  = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            exp_q.delete();
            start_q.delete();
            prev_valid = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_valid && !prev_last) check("contiguous_valid", out_valid, 1);
            if (out_valid) begin
                if (!(prev_valid && !prev_last)) begin
                    if (start_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_start: unexpected frame start at cycle %0d", cyc);
                    end else begin
                        check("frame_start_cycle", cyc, start_q.pop_front());
                    end
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: y0=%0h y1=%0h with nothing expected at cycle %0d", y0, y1, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("y0", y0, e.y0);
                    check("y1", y1, e.y1);
                    check("out_last", out_last, e.last);
                end
            end
            prev_valid = out_valid;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_y0", y0, 0);
        check("rst_y1", y1, 0);
`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
        check("rst_frame_err", frame_err, 0);
`endif

        // Single continuous frame, sample value = natural index.
        send_frame(0, 0, HALF);
        idle(25);

        // Four back-to-back frames.
        send_frame(0, 0, HALF);
        send_frame(0, 100, HALF);
        send_frame(0, -1, HALF);
        send_frame(0, -1, HALF);
        idle(40);

        // Gappy input.
        send_frame(1, 0, HALF);
        idle(25);
        send_frame(2, -1, HALF);
        idle(25);
        send_frame(2, -1, HALF);
        send_frame(2, -1, HALF);
        idle(40);

        // Reset part way through a frame; the next frame must be clean.
        send_frame(0, -1, 7);
        do_reset();
        send_frame(0, 0, HALF);
        idle(25);

        // Reset while output beat 5 is on the bus.
        send_frame(0, -1, HALF);
        n = cyc;
        while (cyc < n + 8) idle(1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_read_out_valid", out_valid, 0);
        check("rst_read_out_last", out_last, 0);
        idle(20);
        send_frame(2, -1, HALF);
        idle(25);

`ifdef FFT_OUT_REORDER_ALIGN_CHECK_EN
        // in_last on beat 9 aborts the frame and sets the sticky error.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x0 = DW'($urandom);
            x1 = DW'($urandom);
            in_last = (c == 9);
        end
        idle(2);
        @(negedge clk);
        check("frame_err_set", frame_err, 1);
        send_frame(0, 0, HALF);
        idle(25);
        @(negedge clk);
        check("frame_err_sticky", frame_err, 1);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_starts_consumed", start_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
